elastic_tfifo_ready_break: RTL and testbench
============================================

// Module: elastic_tfifo_ready_break
// PURPOSE
//  Transparent elastic FIFO: NUM_SLOTS-deep valid/ready buffer whose ins_ready is purely
//  registered (no combinational outs_ready->ins_ready path). Complements the standard
//  elastic FIFO, which cuts the valid path but passes ready combinationally. Inserted by
//  the buffer-placement pass wherever a long backward (ready) path must be broken.
// PARAMETERS
//  NUM_SLOTS  2   storage depth, >=1, any integer (non-power-of-2 allowed)
//  DATA_TYPE  32  data width in bits
// PORTS
//  clk         in   1          clock, all state updates on rising edge
//  rst         in   1          synchronous, active-high reset
//  ins         in   DATA_TYPE  upstream data
//  ins_valid   in   1          upstream valid
//  ins_ready   out  1          upstream ready; function of registered state only
//  outs        out  DATA_TYPE  downstream data
//  outs_valid  out  1          downstream valid
//  outs_ready  in   1          downstream ready
// BEHAVIOUR
//  - State: Memory[NUM_SLOTS], Head, Tail (width max(1,$clog2(NUM_SLOTS))), Count (0..NUM_SLOTS),
//    derived Empty=(Count==0), Full=(Count==NUM_SLOTS). Wrap: ptr==NUM_SLOTS-1 -> 0.
//  - Reset (rst=1 at edge): Head=Tail=Count=0. While rst is high: ins_ready=0, outs_valid=0;
//    Memory contents are not reset. Reset mid-operation discards all stored tokens.
//  - ins_ready = ~Full (registered). Must never depend combinationally on outs_ready.
//  - in_xfer = ins_valid & ins_ready; out_xfer = outs_valid & outs_ready.
//  - Empty & bypass (see CONFIGURATION): outs=ins, outs_valid=ins_valid, 0-cycle latency;
//    if outs_ready=1 the token passes through and is NOT written (Count unchanged).
//  - Non-empty: outs=Memory[Head], outs_valid=1; FIFO order strictly preserved (bypass only
//    when Empty, so a new token never overtakes stored ones).
//  - Write: in_xfer & ~bypassed -> Memory[Tail]<=ins, Tail++. Read: out_xfer & ~Empty -> Head++.
//  - Count: +1 on write only, -1 on read only, unchanged on both/neither.
//  - Full & outs_ready=1: read occurs, ins_ready stays 0 that cycle (1-cycle bubble accepted);
//    ins_ready=1 next cycle.
//  - Empty & ins_valid=0: outs_valid=0, outs is don't-care.
//  - Data held stable at outs while outs_valid=1 & outs_ready=0 (stored token).
//    In bypass, stability is the upstream's obligation.
// CONFIGURATION
//  ELASTIC_TFIFO_BYPASS_EN defined: transparent bypass as above (0-cycle latency when empty).
//  Not defined: no bypass; outs_valid=~Empty, outs=Memory[Head]; every token is written,
//  giving 1-cycle minimum latency. ins_ready remains ~Full. The block then cuts both paths.
// TESTING (run with and without ELASTIC_TFIFO_BYPASS_EN)
//  1 Reset: rst=1 for 2 cycles with ins_valid=1 -> ins_ready=0, outs_valid=0; after release,
//    Count=0 and ins_ready=1.
//  2 Pass-through, NUM_SLOTS=2, outs_ready=1, ins=0xA,0xB,0xC on back-to-back cycles ->
//    bypass: outs=0xA,0xB,0xC in the same cycles; no bypass: each token appears one cycle
//    later, 1 token/cycle.
//  3 Fill/backpressure, outs_ready=0, push 0x1,0x2 -> ins_ready=0 after 2nd write. A 3rd
//    token with ins_valid held is not accepted; outs=0x1 stable.
//  4 Full drain, from full raise outs_ready -> 0x1 then 0x2 out. ins_ready=0 in the first
//    drain cycle, 1 the next; 3rd token (0x3) accepted then, order 0x1,0x2,0x3.
//  5 Wrap, NUM_SLOTS=3, random valid/ready 500 cycles -> scoreboard order and no
//    loss/duplication; Count never >3.
//  6 Combinational check: toggle outs_ready with state frozen -> ins_ready unchanged in
//    the same cycle.

Source files
------------

// File: rtl/elastic_tfifo_ready_break.sv
// elastic_tfifo_ready_break
// Elastic valid/ready FIFO whose upstream ready comes only from registered
// state, so it breaks a long backward (ready) path. Head/tail pointers wrap
// at NUM_SLOTS, so the depth does not have to be a power of two.
// Optional feature macro: ELASTIC_TFIFO_BYPASS_EN. When it is defined, an
// empty FIFO forwards the incoming token to the output in the same cycle.
// When it is not defined, every token is stored first, which adds at least
// one cycle of latency and cuts both the valid and ready paths.
module elastic_tfifo_ready_break #(
  parameter int NUM_SLOTS = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_TYPE-1:0] ins,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  output logic [DATA_TYPE-1:0] outs,
  output logic                 outs_valid,
  input  logic                 outs_ready
);

  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [PW-1:0] LastPtr = PW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] FullCount = CW'(NUM_SLOTS);

  logic [DATA_TYPE-1:0] r_mem [0:NUM_SLOTS-1];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_inXfer;
  logic w_outXfer;
  logic w_write;
  logic w_read;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCount);

  // Ready depends only on the occupancy register and reset, never on outs_ready.
  // A full FIFO therefore keeps ready low even while it drains, which costs
  // one bubble cycle.
  assign ins_ready = ~w_full & ~rst;

`ifdef ELASTIC_TFIFO_BYPASS_EN
  // An empty FIFO is transparent. A token that is consumed in the same cycle
  // is never written to memory.
  assign outs_valid = ~rst & (w_empty ? ins_valid : 1'b1);
  assign outs       = w_empty ? ins : r_mem[r_head];
  assign w_bypass   = w_empty & ins_valid & outs_ready;
`else
  // Without bypass the output always comes from storage.
  assign outs_valid = ~rst & ~w_empty;
  assign outs       = r_mem[r_head];
  assign w_bypass   = 1'b0;
`endif

  assign w_inXfer  = ins_valid & ins_ready;
  assign w_outXfer = outs_valid & outs_ready;
  assign w_write   = w_inXfer & ~w_bypass;
  assign w_read    = w_outXfer & ~w_empty;

  // The storage array is not reset. Only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_tail] <= ins;
    end
  end

  // Pointer and occupancy update. Reset discards every stored token.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_tail <= (r_tail == LastPtr) ? '0 : r_tail + PW'(1);
      end
      if (w_read) begin
        r_head <= (r_head == LastPtr) ? '0 : r_head + PW'(1);
      end
      if (w_write && !w_read) begin
        r_count <= r_count + CW'(1);
      end else if (w_read && !w_write) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_elastic_tfifo_ready_break.sv
// Testbench for elastic_tfifo_ready_break. Expected values depend on whether
// ELASTIC_TFIFO_BYPASS_EN is defined.
module tb_elastic_tfifo_ready_break;

`ifdef ELASTIC_TFIFO_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = '0;
  logic        insValid = 1'b0;
  logic        insReady;
  logic [31:0] outs;
  logic        outsValid;
  logic        outsReady = 1'b0;

  logic [31:0] ins3 = '0;
  logic        insValid3 = 1'b0;
  logic        insReady3;
  logic [31:0] outs3;
  logic        outsValid3;
  logic        outsReady3 = 1'b0;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic        rst;
    logic        insValid;
    logic [31:0] ins;
    logic        outsReady;
    logic        expReady;
    logic        expValid;
    logic [31:0] expOuts;
  } vec_t;

  vec_t vecs [20];

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

  elastic_tfifo_ready_break #(.NUM_SLOTS(2), .DATA_TYPE(32)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(insValid), .ins_ready(insReady),
    .outs(outs), .outs_valid(outsValid), .outs_ready(outsReady)
  );

  elastic_tfifo_ready_break #(.NUM_SLOTS(3), .DATA_TYPE(32)) dut3 (
    .clk(clk), .rst(rst), .ins(ins3), .ins_valid(insValid3), .ins_ready(insReady3),
    .outs(outs3), .outs_valid(outsValid3), .outs_ready(outsReady3)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] d, input logic ordy);
    @(negedge clk);
    rst       = r;
    insValid  = iv;
    ins       = d;
    outsReady = ordy;
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                              input logic ordy, input logic er, input logic ev,
                              input logic [31:0] eo);
    vec_t v;
    v.rst = r; v.insValid = iv; v.ins = d; v.outsReady = ordy;
    v.expReady = er; v.expValid = ev; v.expOuts = eo;
    return v;
  endfunction

  initial begin
    logic [31:0] q [$];
    logic [31:0] sendIdx;
    logic [31:0] front;

    // Reset with valid held high, then pass-through, fill, drain and reset discard.
    vecs[0]  = mk(1, 1, 32'h5, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 1, 32'h5, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0, 1, 1, 0, 32'h0);
    vecs[3]  = mk(0, 1, 32'hA, 1, 1, Byp ? 1'b1 : 1'b0, 32'hA);
    vecs[4]  = mk(0, 1, 32'hB, 1, 1, 1, Byp ? 32'hB : 32'hA);
    vecs[5]  = mk(0, 1, 32'hC, 1, 1, 1, Byp ? 32'hC : 32'hB);
    vecs[6]  = mk(0, 0, 32'h0, 1, 1, Byp ? 1'b0 : 1'b1, 32'hC);
    vecs[7]  = mk(0, 0, 32'h0, 0, 1, 0, 32'h0);
    vecs[8]  = mk(0, 1, 32'h1, 0, 1, Byp ? 1'b1 : 1'b0, 32'h1);
    vecs[9]  = mk(0, 1, 32'h2, 0, 1, 1, 32'h1);
    vecs[10] = mk(0, 1, 32'h3, 0, 0, 1, 32'h1);
    vecs[11] = mk(0, 1, 32'h3, 0, 0, 1, 32'h1);
    vecs[12] = mk(0, 1, 32'h3, 1, 0, 1, 32'h1);
    vecs[13] = mk(0, 1, 32'h3, 1, 1, 1, 32'h2);
    vecs[14] = mk(0, 0, 32'h0, 1, 1, 1, 32'h3);
    vecs[15] = mk(0, 0, 32'h0, 1, 1, 0, 32'h0);
    vecs[16] = mk(0, 1, 32'h11, 0, 1, Byp ? 1'b1 : 1'b0, 32'h11);
    vecs[17] = mk(0, 1, 32'h22, 0, 1, 1, 32'h11);
    vecs[18] = mk(1, 0, 32'h0, 0, 0, 0, 32'h0);
    vecs[19] = mk(0, 0, 32'h0, 1, 1, 0, 32'h0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].insValid, vecs[i].ins, vecs[i].outsReady);
      checkOutput($sformatf("vec%0d ins_ready", i), 32'(insReady), 32'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d outs_valid", i), 32'(outsValid), 32'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d outs", i), outs, vecs[i].expOuts);
      end
    end

    // Fill to full, then toggle outs_ready inside one cycle: ready must not move.
    applyStimulus(0, 1, 32'h33, 0);
    applyStimulus(0, 1, 32'h44, 0);
    applyStimulus(0, 0, 32'h0, 0);
    checkOutput("comb ready full r0", 32'(insReady), 32'h0);
    outsReady = 1'b1;
    #1;
    checkOutput("comb ready full r1", 32'(insReady), 32'h0);
    checkOutput("comb outs full", outs, 32'h33);
    outsReady = 1'b0;
    #1;
    checkOutput("comb ready full r0b", 32'(insReady), 32'h0);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("drain1 ready", 32'(insReady), 32'h0);
    checkOutput("drain1 outs", outs, 32'h33);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("drain2 ready", 32'(insReady), 32'h1);
    checkOutput("drain2 outs", outs, 32'h44);
    applyStimulus(0, 0, 32'h0, 1);
    checkOutput("drained valid", 32'(outsValid), 32'h0);

    // Random valid/ready on the 3-slot instance against a queue scoreboard.
    sendIdx = 32'h100;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      insValid3  = 1'($urandom_range(0, 1));
      outsReady3 = 1'($urandom_range(0, 1));
      ins3       = sendIdx;
      #1;
      checkOutput("rand ins_ready", 32'(insReady3), 32'(q.size() < 3));
      checkOutput("rand outs_valid", 32'(outsValid3),
                  32'((q.size() != 0) || (Byp && insValid3)));
      if (insValid3 && insReady3) begin
        q.push_back(ins3);
        sendIdx = sendIdx + 32'd1;
      end
      if (outsValid3 && outsReady3) begin
        if (q.size() == 0) begin
          checkOutput("rand underflow", 32'd1, 32'd0);
        end else begin
          front = q.pop_front();
          checkOutput("rand order", outs3, front);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
